div_unit: RTL and testbench

//  Multi-cycle 32-bit DIV/DIVU execution unit: the producer side of the HI/LO register pair.

---
 rtl/div_unit_pkg.sv | 26 ++
 rtl/div_unit_if.sv | 40 ++++
 rtl/div_unit.sv | 168 ++++++++++++++++
 tb/tb_div_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit_pkg
//  Purpose  : Shared constants and state encoding for the multi-cycle
//             DIV/DIVU unit and its request/result interface.
//  Contents : c_data_w     - default operand width
//             c_cnt_w      - default iteration counter width
//             c_rst_enable - reset level (reset is active-low)
//             div_state_e  - 2-bit FSM state encoding
//  Revision : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

  localparam int unsigned c_data_w     = 32;
  localparam int unsigned c_cnt_w      = 6;
  localparam logic        c_rst_enable = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

endpackage : div_unit_pkg
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit_if
//  Purpose  : Request/result bundle between the EX stage and the divider.
//  Signals  : signed_div_i - 1 = DIV (two's complement), 0 = DIVU
//             opdata1_i    - dividend
//             opdata2_i    - divisor
//             start_i      - request, only honoured while the unit is idle
//             annul_i      - pipeline flush, aborts the operation
//             result_o     - {remainder -> HI, quotient -> LO}, registered
//             ready_o      - one-cycle pulse, result_o valid / write HI/LO
//  Modports : master (EX side), slave (divider side)
//  Revision : 1.0 - initial release
// ============================================================================
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = c_data_w
);

  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface : div_unit_if
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Purpose  : Multi-cycle DIV/DIVU unit, radix-2 restoring division, one
//             quotient bit per cycle. Produces {remainder, quotient} for the
//             HI/LO register pair.
//  Ports    : clk - clock, all state on the rising edge
//             rst - synchronous reset, active low
//             bus - div_unit_if.slave (request in, result/ready out)
//  Timing   : accept on edge T -> ready_o after edge T+DATA_W+1;
//             divide-by-zero -> ready_o after edge T+2.
//  Revision : 1.0 - initial release
// ============================================================================
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = c_data_w,
  parameter int unsigned CNT_W  = c_cnt_w
) (
  input  wire logic  clk,
  input  wire logic  rst,
  div_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  div_state_e            r_state;
  div_state_e            w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_rem;        // partial remainder
  logic [DATA_W-1:0]     r_dd;         // dividend, becomes the quotient
  logic [DATA_W-1:0]     r_dsr;        // divisor magnitude
  logic                  r_signed;
  logic                  r_sign_dd;
  logic                  r_sign_q;
  logic [2*DATA_W-1:0]   r_result;
  logic                  r_ready;

  logic                  w_accept;
  logic                  w_op1_neg;
  logic                  w_op2_neg;
  logic [DATA_W-1:0]     w_op1_abs;
  logic [DATA_W-1:0]     w_op2_abs;
  logic [DATA_W:0]       w_hi;
  logic [DATA_W+1:0]     w_diff;
  logic                  w_ge;
  logic [DATA_W-1:0]     w_rem_nxt;
  logic [DATA_W-1:0]     w_q_fix;
  logic [DATA_W-1:0]     w_r_fix;
  logic                  w_unused_ok;

  assign w_accept  = (r_state == DIV_FREE) && bus.start_i && !bus.annul_i;

  // Magnitudes; -0x80000000 wraps to itself and is read as unsigned 2^31.
  assign w_op1_neg = bus.signed_div_i && bus.opdata1_i[DATA_W-1];
  assign w_op2_neg = bus.signed_div_i && bus.opdata2_i[DATA_W-1];
  assign w_op1_abs = w_op1_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign w_op2_abs = w_op2_neg ? -bus.opdata2_i : bus.opdata2_i;

  // The shifted partial remainder can reach 2*divisor-1, so it needs one
  // extra bit, and the trial difference one more for its sign.
  assign w_hi      = {r_rem, r_dd[DATA_W-1]};
  assign w_diff    = {1'b0, w_hi} - {2'b00, r_dsr};
  assign w_ge      = !w_diff[DATA_W+1];
  assign w_rem_nxt = w_ge ? w_diff[DATA_W-1:0] : w_hi[DATA_W-1:0];
  // When the subtraction succeeds the difference is below the divisor, so
  // its bit DATA_W is always zero.
  assign w_unused_ok = w_diff[DATA_W];

  // Remainder follows the dividend's sign.
  assign w_q_fix   = (r_signed && r_sign_q)  ? -r_dd  : r_dd;
  assign w_r_fix   = (r_signed && r_sign_dd) ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst == c_rst_enable) begin
      r_state <= DIV_FREE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      DIV_FREE: begin
        if (w_accept) begin
          w_state_nxt = (bus.opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: begin
        w_state_nxt = bus.annul_i ? DIV_FREE : DIV_END;
      end
      DIV_ON: begin
        if (bus.annul_i) begin
          w_state_nxt = DIV_FREE;
        end else if (r_cnt == c_last_iter) begin
          w_state_nxt = DIV_END;
        end
      end
      DIV_END: begin
        w_state_nxt = DIV_FREE;
      end
      default: begin
        w_state_nxt = DIV_FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == c_rst_enable) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dd      <= '0;
      r_dsr     <= '0;
      r_signed  <= 1'b0;
      r_sign_dd <= 1'b0;
      r_sign_q  <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        DIV_FREE: begin
          if (w_accept) begin
            r_signed  <= bus.signed_div_i;
            r_dd      <= w_op1_abs;
            r_dsr     <= w_op2_abs;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_sign_dd <= w_op1_neg;
            r_sign_q  <= w_op1_neg ^ w_op2_neg;
          end
        end
        DIV_BY_ZERO: begin
          // Clearing the working registers and signs makes END emit zero.
          if (!bus.annul_i) begin
            r_dd      <= '0;
            r_rem     <= '0;
            r_sign_dd <= 1'b0;
            r_sign_q  <= 1'b0;
          end
        end
        DIV_ON: begin
          if (!bus.annul_i) begin
            r_rem <= w_rem_nxt;
            r_dd  <= {r_dd[DATA_W-2:0], w_ge};
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        DIV_END: begin
          if (!bus.annul_i) begin
            r_result <= {w_r_fix, w_q_fix};
            r_ready  <= 1'b1;
          end
        end
        default: begin
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_unit
//  Purpose  : Directed self-checking bench for div_unit: latency, signed and
//             unsigned results, divide-by-zero, annul, reset mid-operation,
//             ignored restarts and operand changes, back-to-back issue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   lat;
  bit   seen;

  div_unit_if bus ();

  div_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a request for one edge (the accept edge T).
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    tick();
    bus.start_i      = 1'b0;
  endtask

  // Returns the edge count since accept at which ready_o is first seen,
  // or -1 if it never shows up within the budget.
  task automatic wait_ready(input int already, output int n);
    n = -1;
    for (int i = already + 1; i <= 80; i++) begin
      tick();
      if (bus.ready_o === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic watch_no_ready(input int cycles, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.ready_o !== 1'b0) hit = 1'b1;
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    tick();
    tick();
    tick();
    chk("reset_result", bus.result_o, 64'h0);
    chk("reset_ready", {63'h0, bus.ready_o}, 64'h0);
    rst = 1'b1;
    tick();

    // DIVU 100/7
    start_op(1'b0, 32'd100, 32'd7);
    wait_ready(0, lat);
    chk("divu_100_7_latency", 64'(lat), 64'd33);
    chk("divu_100_7_result", bus.result_o, {32'd2, 32'd14});

    // Back-to-back: issued in the FREE cycle that carries the ready pulse.
    start_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    chk("ready_one_cycle", {63'h0, bus.ready_o}, 64'h0);
    chk("result_held", bus.result_o, {32'd2, 32'd14});
    wait_ready(0, lat);
    chk("div_m7_2_latency", 64'(lat), 64'd33);
    chk("div_m7_2_result", bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tick();

    start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_ready(0, lat);
    chk("div_7_m2_result", bus.result_o, {32'h0000_0001, 32'hFFFF_FFFD});
    tick();

    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(0, lat);
    chk("div_wrap_result", bus.result_o, {32'h0, 32'h8000_0000});
    tick();

    // Divide by zero
    start_op(1'b0, 32'd5, 32'd0);
    wait_ready(0, lat);
    chk("divzero_latency", 64'(lat), 64'd2);
    chk("divzero_result", bus.result_o, 64'h0);
    tick();

    start_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_ready(0, lat);
    chk("divu_max_1_result", bus.result_o, {32'h0, 32'hFFFF_FFFF});
    tick();

    // Operand changes and start pulses after accept must be ignored.
    start_op(1'b0, 32'd1000, 32'd10);
    tick();
    tick();
    bus.opdata1_i    = 32'h1234_5678;
    bus.opdata2_i    = 32'd3;
    bus.signed_div_i = 1'b1;
    bus.start_i      = 1'b1;
    tick();
    bus.start_i      = 1'b0;
    wait_ready(3, lat);
    chk("ignore_latency", 64'(lat), 64'd33);
    chk("ignore_result", bus.result_o, {32'd0, 32'd100});
    tick();

    // Annul in ON at T+10.
    start_op(1'b0, 32'd50, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    bus.annul_i = 1'b1;
    tick();
    bus.annul_i = 1'b0;
    watch_no_ready(40, seen);
    chk("annul_on_no_ready", {63'h0, seen}, 64'h0);
    chk("annul_on_result_kept", bus.result_o, {32'd0, 32'd100});

    // Start together with annul in FREE is not accepted.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd9;
    bus.opdata2_i    = 32'd4;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b1;
    tick();
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    watch_no_ready(40, seen);
    chk("start_annul_no_ready", {63'h0, seen}, 64'h0);

    // Annul during END: no ready and no result update.
    start_op(1'b0, 32'd77, 32'd5);
    for (int i = 0; i < 32; i++) tick();
    bus.annul_i = 1'b1;
    tick();
    bus.annul_i = 1'b0;
    chk("annul_end_no_ready", {63'h0, bus.ready_o}, 64'h0);
    watch_no_ready(10, seen);
    chk("annul_end_quiet", {63'h0, seen}, 64'h0);
    chk("annul_end_result_kept", bus.result_o, {32'd0, 32'd100});

    // Unit still usable after the aborts.
    start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_ready(0, lat);
    chk("div_m100_7_latency", 64'(lat), 64'd33);
    chk("div_m100_7_result", bus.result_o, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    tick();

    // Reset asserted at T+5 mid-operation.
    start_op(1'b0, 32'd9, 32'd2);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midreset_result", bus.result_o, 64'h0);
    chk("midreset_ready", {63'h0, bus.ready_o}, 64'h0);
    watch_no_ready(40, seen);
    chk("midreset_no_ready", {63'h0, seen}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_div_unit
`default_nettype wire
